// File: rtl/hazard_tracker.sv
// hazard_tracker: tracks EX/MEM/WB destination tags and stalls decode on load-use hazards
module hazard_tracker #(
  parameter logic [4:0] XZR = 5'd31,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rd,
  input  logic             id_wr_en,
  input  logic             id_mem_read,
  input  logic [4:0]       id_rn,
  input  logic [4:0]       id_rm,
  input  logic             id_reg2loc,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic             flush_id,
  output logic             stall,
  output logic [4:0]       ex_wr_reg,
  output logic             ex_wr_en,
  output logic             ex_mem_read,
  output logic [4:0]       mem_wr_reg,
  output logic             mem_wr_en,
  output logic [4:0]       wb_wr_reg,
  output logic             wb_wr_en,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [4:0] src_b;
  logic hazard, bubble;
  always_comb begin
    src_b = id_reg2loc ? id_rm : id_rd;
    hazard = id_valid && ex_wr_en && ex_mem_read && ex_wr_reg != XZR &&
             ((id_uses_a && id_rn == ex_wr_reg) || (id_uses_b && src_b == ex_wr_reg));
    stall = hazard && !flush_id;
    bubble = !id_valid || flush_id || stall;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_wr_reg <= '0;
      ex_wr_en <= 1'b0;
      ex_mem_read <= 1'b0;
      mem_wr_reg <= '0;
      mem_wr_en <= 1'b0;
      wb_wr_reg <= '0;
      wb_wr_en <= 1'b0;
      stall_cnt <= '0;
    end else begin
      ex_wr_reg <= bubble ? 5'd0 : id_rd;
      ex_wr_en <= bubble ? 1'b0 : id_wr_en && id_rd != XZR;
      ex_mem_read <= bubble ? 1'b0 : id_mem_read;
      mem_wr_reg <= ex_wr_reg;
      mem_wr_en <= ex_wr_en;
      wb_wr_reg <= mem_wr_reg;
      wb_wr_en <= mem_wr_en;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: table-driven and scoreboard checks of hazard_tracker (CNT_W=4)
module tb_hazard_tracker;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid, id_wr_en, id_mem_read, id_reg2loc, id_uses_a, id_uses_b, flush_id;
  logic [4:0] id_rd, id_rn, id_rm;
  logic stall, ex_wr_en, ex_mem_read, mem_wr_en, wb_wr_en;
  logic [4:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
  logic [CW-1:0] stall_cnt;
  int total = 0, passed = 0;
  typedef struct {
    logic v; logic [4:0] rd; logic we; logic mr; logic [4:0] rn; logic [4:0] rm;
    logic r2l; logic ua; logic ub; logic fl;
    logic s; logic [4:0] er; logic ee; logic em; logic [CW-1:0] cnt;
  } vec_t;
  typedef struct { logic [4:0] r; logic e; } tag_t;
  vec_t tbl[22];
  tag_t q[$];
  hazard_tracker #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rd(id_rd), .id_wr_en(id_wr_en),
    .id_mem_read(id_mem_read), .id_rn(id_rn), .id_rm(id_rm), .id_reg2loc(id_reg2loc),
    .id_uses_a(id_uses_a), .id_uses_b(id_uses_b), .flush_id(flush_id), .stall(stall),
    .ex_wr_reg(ex_wr_reg), .ex_wr_en(ex_wr_en), .ex_mem_read(ex_mem_read),
    .mem_wr_reg(mem_wr_reg), .mem_wr_en(mem_wr_en), .wb_wr_reg(wb_wr_reg),
    .wb_wr_en(wb_wr_en), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s actual=%0d required=%0d", n, a, e);
    else passed++;
  endtask
  task automatic drive(input vec_t t);
    id_valid = t.v; id_rd = t.rd; id_wr_en = t.we; id_mem_read = t.mr; id_rn = t.rn;
    id_rm = t.rm; id_reg2loc = t.r2l; id_uses_a = t.ua; id_uses_b = t.ub; flush_id = t.fl;
  endtask
  task automatic zeros(input string n);
    chk({n, " stall"}, 32'(stall), 0);
    chk({n, " ex_wr_reg"}, 32'(ex_wr_reg), 0);
    chk({n, " ex_wr_en"}, 32'(ex_wr_en), 0);
    chk({n, " ex_mem_read"}, 32'(ex_mem_read), 0);
    chk({n, " mem_wr_reg"}, 32'(mem_wr_reg), 0);
    chk({n, " mem_wr_en"}, 32'(mem_wr_en), 0);
    chk({n, " wb_wr_reg"}, 32'(wb_wr_reg), 0);
    chk({n, " wb_wr_en"}, 32'(wb_wr_en), 0);
    chk({n, " stall_cnt"}, 32'(stall_cnt), 0);
  endtask
  initial begin
    //         v  rd  we mr rn  rm r2l ua ub fl  s  er  ee em cnt
    tbl[0]  = '{1, 2,  1, 1, 1,  0, 0, 1, 0, 0, 0, 2,  1, 1, 0};
    tbl[1]  = '{1, 9,  1, 0, 2,  3, 1, 1, 1, 0, 1, 0,  0, 0, 1};
    tbl[2]  = '{1, 9,  1, 0, 2,  3, 1, 1, 1, 0, 0, 9,  1, 0, 1};
    tbl[3]  = '{1, 5,  1, 1, 0,  0, 0, 1, 0, 0, 0, 5,  1, 1, 1};
    tbl[4]  = '{1, 5,  0, 0, 1,  7, 0, 1, 1, 0, 1, 0,  0, 0, 2};
    tbl[5]  = '{1, 5,  1, 1, 0,  0, 0, 1, 0, 0, 0, 5,  1, 1, 2};
    tbl[6]  = '{1, 5,  0, 0, 1,  7, 1, 1, 1, 0, 0, 5,  0, 0, 2};
    tbl[7]  = '{1, 31, 1, 1, 0,  0, 0, 0, 0, 0, 0, 31, 0, 1, 2};
    tbl[8]  = '{1, 10, 1, 0, 31, 0, 0, 1, 0, 0, 0, 10, 1, 0, 2};
    tbl[9]  = '{1, 3,  1, 0, 0,  0, 0, 1, 0, 0, 0, 3,  1, 0, 2};
    tbl[10] = '{1, 11, 1, 0, 3,  0, 0, 1, 0, 0, 0, 11, 1, 0, 2};
    tbl[11] = '{1, 2,  1, 1, 0,  0, 0, 0, 0, 0, 0, 2,  1, 1, 2};
    tbl[12] = '{1, 12, 1, 0, 2,  0, 0, 1, 0, 1, 0, 0,  0, 0, 2};
    tbl[13] = '{0, 13, 1, 0, 0,  0, 0, 1, 0, 0, 0, 0,  0, 0, 2};
    tbl[14] = '{1, 4,  1, 0, 0,  0, 0, 1, 0, 0, 0, 4,  1, 0, 2};
    tbl[15] = '{1, 6,  1, 0, 0,  0, 0, 1, 0, 0, 0, 6,  1, 0, 2};
    tbl[16] = '{1, 8,  1, 0, 0,  0, 0, 1, 0, 0, 0, 8,  1, 0, 2};
    tbl[17] = '{1, 1,  1, 1, 0,  0, 0, 0, 0, 0, 0, 1,  1, 1, 2};
    tbl[18] = '{1, 2,  1, 1, 1,  0, 0, 1, 0, 0, 1, 0,  0, 0, 3};
    tbl[19] = '{1, 2,  1, 1, 1,  0, 0, 1, 0, 0, 0, 2,  1, 1, 3};
    tbl[20] = '{1, 7,  1, 0, 2,  0, 0, 1, 0, 0, 1, 0,  0, 0, 4};
    tbl[21] = '{1, 7,  1, 0, 2,  0, 0, 1, 0, 0, 0, 7,  1, 0, 4};
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    #12 reset = 1'b0;
    zeros("reset");
    for (int i = 0; i < 3; i++) q.push_back('{5'd0, 1'b0});
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i]);
      #1 chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].s));
      q.push_back('{tbl[i].er, tbl[i].ee});
      void'(q.pop_front());
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_wr_reg", i), 32'(ex_wr_reg), 32'(q[2].r));
      chk($sformatf("v%0d ex_wr_en", i), 32'(ex_wr_en), 32'(q[2].e));
      chk($sformatf("v%0d ex_mem_read", i), 32'(ex_mem_read), 32'(tbl[i].em));
      chk($sformatf("v%0d mem_wr_reg", i), 32'(mem_wr_reg), 32'(q[1].r));
      chk($sformatf("v%0d mem_wr_en", i), 32'(mem_wr_en), 32'(q[1].e));
      chk($sformatf("v%0d wb_wr_reg", i), 32'(wb_wr_reg), 32'(q[0].r));
      chk($sformatf("v%0d wb_wr_en", i), 32'(wb_wr_en), 32'(q[0].e));
      chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
    end
    drive('{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(posedge clk); #1;
    drive('{1, 9, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    #1 chk("midstall stall", 32'(stall), 1);
    reset = 1'b1;
    #1 zeros("async reset");
    @(posedge clk); #1;
    reset = 1'b0;
    drive('{1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    #1 chk("post reset stall", 32'(stall), 0);
    @(posedge clk); #1;
    chk("post reset ex_wr_reg", 32'(ex_wr_reg), 4);
    chk("post reset ex_wr_en", 32'(ex_wr_en), 1);
    drive('{1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    for (int i = 0; i < 6; i++) @(posedge clk);
    #1 chk("sat partial stall_cnt", 32'(stall_cnt), 3);
    for (int i = 0; i < 34; i++) @(posedge clk);
    #1 chk("sat stall_cnt", 32'(stall_cnt), 15);
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1 chk("sat hold stall_cnt", 32'(stall_cnt), 15);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Tracks destination-register tags of in-flight instructions through the EX, MEM and WB stages of the pipelined LEGv8 core. It sits between decode and the forwarding control logic. It supplies the EX-stage and MEM-stage write tags and enables that the forwarding control consumes. It also detects load-use hazards, requests a one-cycle decode stall and inserts a bubble into EX.

## Interface
Parameters:
- XZR, 5'd31, register index hardwired to zero; writes to it are never tracked.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  decode stage holds a real instruction.
- id_rd  input  5  destination register of decode instruction.
- id_wr_en  input  1  decode instruction writes the register file.
- id_mem_read  input  1  decode instruction is a load (LDUR).
- id_rn  input  5  first source register.
- id_rm  input  5  second source register (R-type).
- id_reg2loc  input  1  1: second source is id_rm; 0: second source is id_rd (STUR/CBZ data).
- id_uses_a  input  1  decode instruction reads the first source.
- id_uses_b  input  1  decode instruction reads the second source.
- flush_id  input  1  kill decode instruction (taken branch).
- stall  output  1  hold PC and IF/ID this cycle (combinational).
- ex_wr_reg  output  5  EX-stage destination tag.
- ex_wr_en  output  1  EX-stage write valid.
- ex_mem_read  output  1  EX-stage instruction is a load.
- mem_wr_reg  output  5  MEM-stage destination tag.
- mem_wr_en  output  1  MEM-stage write valid.
- wb_wr_reg  output  5  WB-stage destination tag.
- wb_wr_en  output  1  WB-stage write valid.
- stall_cnt  output  CNT_W  total stall cycles since reset, saturating.

## Operation
- Second source select: src_b = id_reg2loc ? id_rm : id_rd.
- Hazard condition (combinational): id_valid && ex_wr_en && ex_mem_read && ex_wr_reg != XZR, and either (id_uses_a && id_rn == ex_wr_reg) or (id_uses_b && src_b == ex_wr_reg).
- stall = hazard && !flush_id. A killed instruction never stalls.
- Bubble into EX when any of the following holds: !id_valid, flush_id, or stall. A bubble loads ex_wr_en=0, ex_mem_read=0, ex_wr_reg=0.
- Otherwise EX loads the decode fields: ex_wr_reg=id_rd, ex_wr_en = id_wr_en && id_rd != XZR, ex_mem_read=id_mem_read.
- ex_mem_read is captured independently of the XZR rule. A load to XZR has ex_wr_en=0 and therefore never creates a hazard.
- The pipeline always advances. MEM <= EX and WB <= MEM every cycle, including stall cycles. There is no stage enable.
- stall_cnt increments by 1 on each rising edge where stall=1. It saturates at 2^CNT_W-1 and never wraps.
- Stall length is exactly one cycle. On the following cycle the load is in MEM, and the hazard condition is false because EX holds the bubble. The consumer then gets data via MEM forwarding.
- A decode instruction that was stalled is re-presented unchanged by upstream. It is accepted on the next cycle.

## Timing
- stall is combinational from the decode inputs and the EX registers, valid in the same cycle.
- Tag latency: the decode instruction appears on ex_* 1 cycle after acceptance, on mem_* after 2 cycles, and on wb_* after 3 cycles.
- Reset (asynchronous, any time, including mid-stall) has these effects:
  - all *_wr_en, ex_mem_read and *_wr_reg go to 0 immediately;
  - stall_cnt goes to 0;
  - stall therefore drops to 0 immediately.
- Reset deassertion: the first rising edge after deassertion captures decode normally.
- Simultaneous flush_id and hazard: stall=0, EX gets a bubble, and stall_cnt is unchanged.
- Back-to-back loads where the second depends on the first: one stall, then the second load enters EX. A third dependent instruction stalls again, for two stalls in total.

## Test plan
- Load-use hazard via first source: LDUR X2 in EX (ex_mem_read=1, ex_wr_reg=2), decode ADD with id_rn=2, id_uses_a=1. Required response:
  - stall=1 this cycle;
  - next cycle ex_wr_en=0, mem_wr_reg=2, mem_wr_en=1, stall=0;
  - stall_cnt=1.
- Store data hazard via second source: LDUR X5 in EX, decode STUR with id_reg2loc=0, id_rd=5, id_uses_b=1. Required response: stall=1. With id_reg2loc=1 and id_rm=7, stall=0.
- XZR and non-load cases: LDUR XZR in EX with decode rn=31 gives stall=0 and ex_wr_en=0. ADD X3 in EX (not a load) with decode rn=3 gives stall=0.
- Flush priority: hazard present and flush_id=1 gives stall=0, next ex_wr_en=0, and stall_cnt unchanged.
- Tag pipeline: ADD X4, SUB X6, ORR X8 issued on consecutive cycles. At the cycle after the third issue, the required values are ex_wr_reg=8, mem_wr_reg=6 and wb_wr_reg=4, all with write enables 1.
- Reset mid-stall: assert reset asynchronously while stall=1. All outputs must go to 0 before the next clock edge. Also force stall_cnt to 2^CNT_W-1 (CNT_W=4 build) and apply further stalls; the counter must hold at 15.
